fp16_mult_result_stage: RTL
===========================

// Module: fp16_mult_result_stage
// PURPOSE
//  Output stage directly downstream of the FP16 multiplier core. Captures {result, flags} per product
//  through a valid/ready 2-entry skid buffer. Keeps sticky IEEE exception flags and a transfer counter.
//  Decouples the multiplier from a stalling consumer (accumulator or writeback) without dropping products.
// PARAMETERS
//  DWIDTH   16  FP word width: sign, 5-bit exponent, 10-bit mantissa
//  FLAGW    5   flag vector width: {any_exc, a_nan, b_nan, a_inf, b_inf}
//  CNTW     16  width of the out_count transfer counter
// PORTS
//  clk           in   1       single clock; all state updates on rising edge
//  rst           in   1       synchronous, active-high reset
//  in_valid      in   1       multiplier product valid
//  in_ready      out  1       stage can accept; taken from the state register only (no comb path from out_ready)
//  in_result     in   DWIDTH  FP16 product
//  in_flags      in   FLAGW   exception flags belonging to in_result
//  out_valid     out  1       out_result/out_flags valid
//  out_ready     in   1       consumer accepts
//  out_result    out  DWIDTH  product held in the main register
//  out_flags     out  FLAGW   flags held in the main register
//  clr_sticky    in   1       clears sticky_flags
//  sticky_flags  out  FLAGW   OR of in_flags over all accepted products since the last clear or reset
//  out_count     out  CNTW    number of completed output transfers, modulo 2^CNTW
// BEHAVIOUR
//  accept = in_valid & in_ready; pop = out_valid & out_ready.
//  Reset (rst=1 at an edge): state=EMPTY; out_valid=0; out_result=0; out_flags=0; sticky_flags=0; out_count=0.
//  in_ready=0 while rst is high; in_ready=1 from the first cycle after rst drops.
//  FSM states: EMPTY (no entry), ONE (main full), TWO (main+skid full).
//   EMPTY: accept -> ONE, main<=in.
//   ONE: accept & !pop -> TWO, skid<=in. pop & !accept -> EMPTY. accept & pop -> ONE, main<=in.
//   TWO: in_ready=0. pop -> ONE, main<=skid. Otherwise hold.
//  in_ready = (state != TWO) & !rst. out_valid = (state != EMPTY).
//  Latency: a product accepted at edge k appears on out_* after edge k, so out_valid is high in cycle k+1.
//  Ordering: products leave in strict acceptance order. No loss and no duplication under any valid/ready pattern.
//  out_* hold stable while out_valid=1 and out_ready=0.
//  Sticky register at each edge:
//   sticky <= (clr_sticky ? 0 : sticky) | (accept ? in_flags_eff : 0).
//   When clr_sticky and accept occur in the same cycle, the new flags survive the clear.
//  out_count increments by 1 on every pop and wraps from 2^CNTW-1 to 0.
//  rst mid-transfer discards both buffered entries. No output is produced for them.
// CONFIGURATION
//  FP16_RES_NAN_CANON_EN defined:
//   If in_flags[3] or in_flags[2] is set (a NaN operand), the result is stored as the canonical qNaN 16'h7E00.
//   Else if in_flags[1] or in_flags[0] is set (an Inf operand), the result is stored as {in_result[15], 5'h1F, 10'h000}.
//   Canonicalisation is applied at capture time. Flags pass through unchanged.
//  FP16_RES_NAN_CANON_EN undefined: in_result is stored unmodified (in_flags_eff = in_flags in both cases).
// STRUCTURE
//  Shared package fp16_mult_pkg holds:
//   DWIDTH, FLAGW, flag bit indices (FLG_ANY=4, FLG_ANAN=3, FLG_BNAN=2, FLG_AINF=1, FLG_BINF=0),
//   the state typedef {EMPTY, ONE, TWO}, and the constant FP16_QNAN=16'h7E00.
//  One sub-module, fp16_skid_buffer: generic 2-entry valid/ready skid buffer of width DWIDTH+FLAGW.
//  The top level adds canonicalisation, sticky flags and the counter.
// TESTING
//  1 Reset: hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, sticky=0, out_count=0 throughout.
//  2 Streaming: out_ready=1, push 0x3C00,0x4000,0x4200 back-to-back -> same words on consecutive cycles,
//    each 1 cycle after accept; out_count=3.
//  3 Backpressure: out_ready=0, push 0x3C00,0x4000 -> in_ready=0 after the 2nd accept. out_ready=1 for 2 cycles
//    -> 0x3C00 then 0x4000; in_ready=1 again after the 1st pop.
//  4 Sticky: accept flags 5'b10010 then 5'b10001 -> sticky=5'b10011. clr_sticky together with an accept of
//    flags 5'b10100 -> sticky=5'b10100.
//  5 Canon: in_result=0xFE55, flags=5'b11000 -> out 0x7E00 with macro, 0xFE55 without.
//    in_result=0xFC00, flags=5'b10001 -> 0xFC00 in both builds.
//  6 Wrap: set CNTW=4, complete 17 transfers -> out_count=1. Assert rst with TWO entries held -> out_valid=0
//    next cycle and neither entry is ever output.

Source files
------------

// File: rtl/fp16_mult_pkg.sv
// Shared definitions for the FP16 multiplier result path: widths, flag bit positions,
// buffer state encoding and the canonical quiet NaN.
`default_nettype none

package fp16_mult_pkg;

    localparam int DWIDTH = 16;
    localparam int FLAGW  = 5;

    localparam int FLG_ANY  = 4;
    localparam int FLG_ANAN = 3;
    localparam int FLG_BNAN = 2;
    localparam int FLG_AINF = 1;
    localparam int FLG_BINF = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;

endpackage

`default_nettype wire

// File: rtl/fp16_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer; in_ready depends only on the state register
// and rst, so there is no combinational path from out_ready back to in_ready.
`default_nettype none

module fp16_skid_buffer
    import fp16_mult_pkg::*;
#(
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    buf_state_e       state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             accept;
    logic             pop;

    assign in_ready  = (state_q != TWO) & ~rst;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q <= ONE;
                        main_q  <= in_data;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        state_q <= TWO;
                        skid_q  <= in_data;
                    end else if (pop && !accept) begin
                        state_q <= EMPTY;
                    end else if (accept && pop) begin
                        main_q  <= in_data;
                    end
                end
                TWO: begin
                    // in_ready is low here, so a pop is the only way out
                    if (pop) begin
                        state_q <= ONE;
                        main_q  <= skid_q;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp16_mult_result_stage.sv
// FP16 multiplier output stage: skid-buffered {flags, result}, sticky exception flags and a
// transfer counter. Optional NaN/Inf result canonicalisation under FP16_RES_NAN_CANON_EN.
`default_nettype none

module fp16_mult_result_stage
    import fp16_mult_pkg::*;
#(
    parameter int DWIDTH = fp16_mult_pkg::DWIDTH,
    parameter int FLAGW  = fp16_mult_pkg::FLAGW,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_result,
    input  logic [FLAGW-1:0]  in_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_result,
    output logic [FLAGW-1:0]  out_flags,
    input  logic              clr_sticky,
    output logic [FLAGW-1:0]  sticky_flags,
    output logic [CNTW-1:0]   out_count
);

    logic [DWIDTH-1:0]       result_eff;
    logic [FLAGW+DWIDTH-1:0] buf_out;
    logic                    accept;
    logic                    pop;
    logic [FLAGW-1:0]        sticky_q;
    logic [FLAGW-1:0]        sticky_d;
    logic [CNTW-1:0]         count_q;
    logic [CNTW-1:0]         count_d;

`ifdef FP16_RES_NAN_CANON_EN
    // NaN operand dominates Inf operand; the product sign is kept for Inf
    always_comb begin
        result_eff = in_result;
        if (in_flags[FLG_ANAN] || in_flags[FLG_BNAN]) begin
            result_eff = FP16_QNAN;
        end else if (in_flags[FLG_AINF] || in_flags[FLG_BINF]) begin
            result_eff = {in_result[DWIDTH-1], 5'h1F, 10'h000};
        end
    end
`else
    assign result_eff = in_result;
`endif

    fp16_skid_buffer #(
        .WIDTH (FLAGW + DWIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_flags, result_eff}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out)
    );

    assign out_result = buf_out[DWIDTH-1:0];
    assign out_flags  = buf_out[FLAGW+DWIDTH-1:DWIDTH];

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // Flags of a product accepted in the clearing cycle survive the clear
    assign sticky_d = (clr_sticky ? '0 : sticky_q) | (accept ? in_flags : '0);
    assign count_d  = pop ? count_q + CNTW'(1) : count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
            count_q  <= '0;
        end else begin
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign sticky_flags = sticky_q;
    assign out_count    = count_q;

endmodule

`default_nettype wire
